// File: rtl/spiio_slave.sv
// SPI target (Mode 0, MSB first, 8/16-bit frames) with CPU-visible rx/tx holding registers on the SuperIO register bus.
// Latency: pin edges act SYNC_STAGES+2 clk after the pin change; register reads return DO one clock after the cs & rw edge.
// Backpressure: none on SPI (the master owns timing); an unread rx word causes later frames to be dropped with OVR set, a missing tx word sends fill.
module spiio_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    // Synchronizers and registered edge pulses
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   ss_d;
    logic                   mosi_d;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   ss_fall;
    logic                   ss_rise;

    // Shift engine
    logic [4:0]  bit_cnt;
    logic [14:0] shift_rx;
    logic [15:0] shift_tx;
    logic        frame_16b;

    // CPU-visible state
    logic [15:0] rx_data;
    logic [15:0] tx_data;
    logic [7:0]  fill;
    logic        rxf;
    logic        txf;
    logic        txe;
    logic        ovr;
    logic        cfg_16b;
    logic        rie;
    logic        tie;

    // Decoded strobes and datapath helpers
    logic        sel;
    logic        wr;
    logic        rd;
    logic        rd1;
    logic        wr1;
    logic        wr2;
    logic [4:0]  n_bits;
    logic [15:0] rx_word;
    logic [15:0] rx_new;
    logic [15:0] tx_load;
    logic        load_req;
    logic        frame_done;
    logic        rx_take;
    logic        rx_ovr;
    logic [7:0]  status;
    logic [7:0]  rd_val;

    // The edge pulse is registered one stage past the last sync flop; mosi_d keeps mosi aligned with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
            mosi_d    <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
            sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_d;
            sck_fall  <= ~sck_sync[SYNC_STAGES-1] & sck_d;
            ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_d;
            ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_d;
        end
    end

    // Bus decode, frame bookkeeping and the word that a shift_tx load would take
    always_comb begin
        sel        = ~ss_d;
        wr         = cs & ~rw;
        rd         = cs & rw;
        rd1        = rd & (AD == 3'd1);
        wr1        = wr & (AD == 3'd1);
        wr2        = wr & (AD == 3'd2);
        n_bits     = frame_16b ? 5'd16 : 5'd8;
        rx_word    = {shift_rx, mosi_d};
        rx_new     = frame_16b ? rx_word : {8'h00, rx_word[7:0]};
        tx_load    = txf ? tx_data : {8'hFF, fill};
        load_req   = ss_fall | (sel & sck_fall & (bit_cnt == 5'd0));
        frame_done = sel & sck_rise & ((bit_cnt + 5'd1) == n_bits);
        // A read of $1 on the completion clock frees the holding register for the new word
        rx_take    = frame_done & (~rxf | rd1);
        rx_ovr     = frame_done & rxf & ~rd1;
        status     = {rxf, txe, ovr, sel, cfg_16b, 1'b0, rie, tie};
        case (AD)
            3'd0:    rd_val = rx_data[15:8];
            3'd1:    rd_val = rx_data[7:0];
            3'd2:    rd_val = status;
            3'd3:    rd_val = fill;
            default: rd_val = 8'h00;
        endcase
    end

    // Bit counter and shift registers; ss_n edges take priority over sck edges
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt   <= 5'd0;
            shift_rx  <= 15'd0;
            shift_tx  <= 16'hFFFF;
            frame_16b <= 1'b0;
        end else if (ss_fall) begin
            frame_16b <= cfg_16b;
            bit_cnt   <= 5'd0;
            shift_tx  <= tx_load;
        end else if (ss_rise) begin
            bit_cnt   <= 5'd0;
        end else if (sel) begin
            if (sck_rise) begin
                shift_rx <= rx_word[14:0];
                bit_cnt  <= frame_done ? 5'd0 : bit_cnt + 5'd1;
            end
            if (sck_fall) begin
                if (bit_cnt == 5'd0) begin
                    shift_tx <= tx_load;
                end else begin
                    shift_tx <= {shift_tx[14:0], 1'b1};
                end
            end
        end
    end

    // Holding registers and status flags; CPU writes win over same-edge hardware updates of TXF/TXE
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data <= 16'h0000;
            tx_data <= 16'hFFFF;
            fill    <= 8'hFF;
            rxf     <= 1'b0;
            txf     <= 1'b0;
            txe     <= 1'b1;
            ovr     <= 1'b0;
            cfg_16b <= 1'b0;
            rie     <= 1'b0;
            tie     <= 1'b0;
        end else begin
            if (wr && AD == 3'd0) begin
                tx_data[15:8] <= DI;
            end
            if (wr1) begin
                tx_data[7:0] <= DI;
            end
            if (wr && AD == 3'd3) begin
                fill <= DI;
            end
            if (wr2) begin
                cfg_16b <= DI[3];
                rie     <= DI[1];
                tie     <= DI[0];
            end
            if (wr1) begin
                txf <= 1'b1;
                txe <= 1'b0;
            end else if (load_req && txf) begin
                txf <= 1'b0;
                txe <= 1'b1;
            end
            if (rx_take) begin
                rx_data <= rx_new;
                rxf     <= 1'b1;
            end else if (rd1) begin
                rxf     <= 1'b0;
            end
            if (rx_ovr) begin
                ovr <= 1'b1;
            end else if (rd1 && !frame_done) begin
                ovr <= 1'b0;
            end else if (wr2 && DI[5]) begin
                ovr <= 1'b0;
            end
        end
    end

    // Registered read data, updated only on read cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            DO <= 8'h00;
        end else if (rd) begin
            DO <= rd_val;
        end
    end

    assign irq     = (rie & (rxf | ovr)) | (tie & txe);
    assign miso    = sel ? (frame_16b ? shift_tx[15] : shift_tx[7]) : 1'b1;
    assign miso_oe = sel;

endmodule
